ram_arb_sdp: RTL and testbench

Parametrised simple-dual-port RAM with one write port and `NUM_RD` arbitrated read channels that share a single physical read port. It replaces the fixed 8-bit RAM/VRAM wrapper pair with one generic block. The CPU and the LCD text fetcher can then share one memory through a request/grant/valid handshake, with configurable data width, depth and output register. It sits between the CPU/video clients and inferred block RAM, all on `MEMORY_CLK`.

---
 rtl/ram_arb_sdp.sv | 128 ++++++++++++
 tb/tb_ram_arb_sdp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arb_sdp.sv
// ram_arb_sdp: simple-dual-port RAM with one write port and NUM_RD round-robin arbitrated read channels.
// Optional macro RAM_WR_BYPASS_EN: a same-cycle, same-address read returns the new write data.
module ram_arb_sdp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_RD     = 2,
  parameter int OUT_REG    = 1
) (
  input  logic                         MEMORY_CLK,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            rd_gnt,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [NUM_RD-1:0]     w_gnt;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [NUM_RD-1:0]     r_tag1;
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic [DATA_WIDTH-1:0] w_s1_data;

  // Search from r_rr_ptr upward with wrap; the first requester wins.
  always_comb begin : p_arb
    int c;
    c         = 0;
    w_gnt     = '0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      c = (int'(r_rr_ptr) + k) % NUM_RD;
      if (w_gnt == '0 && rd_req[c]) begin
        w_gnt[c]  = 1'b1;
        w_gnt_idx = PTR_W'(c);
      end
    end
    if (reset) begin
      w_gnt     = '0;
      w_gnt_idx = '0;
    end
  end

  assign rd_gnt    = w_gnt;
  assign w_issue   = |w_gnt;
  assign w_rd_addr = rd_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  always_ff @(posedge MEMORY_CLK) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= PTR_W'((int'(w_gnt_idx) + 1) % NUM_RD);
    end
  end

  // NOTE: the array is never reset so it can map onto block RAM; only control and pipeline state reset.
  always_ff @(posedge MEMORY_CLK) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: non-blocking updates mean a same-edge read samples the pre-write word (old-data collision).
  always_ff @(posedge MEMORY_CLK) begin
    if (reset) begin
      r_tag1  <= '0;
      r_ram_q <= '0;
    end else begin
      r_tag1 <= w_gnt;
      if (w_issue) begin
        r_ram_q <= r_mem[w_rd_addr];
      end
    end
  end

`ifdef RAM_WR_BYPASS_EN
  logic                  r_byp;
  logic [DATA_WIDTH-1:0] r_byp_data;

  always_ff @(posedge MEMORY_CLK) begin
    if (reset) begin
      r_byp      <= 1'b0;
      r_byp_data <= '0;
    end else if (w_issue) begin
      r_byp      <= wr_en && (wr_addr == w_rd_addr);
      r_byp_data <= wr_data;
    end
  end

  assign w_s1_data = r_byp ? r_byp_data : r_ram_q;
`else
  assign w_s1_data = r_ram_q;
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [NUM_RD-1:0]     r_tag2;
      logic [DATA_WIDTH-1:0] r_data2;

      always_ff @(posedge MEMORY_CLK) begin
        if (reset) begin
          r_tag2  <= '0;
          r_data2 <= '0;
        end else begin
          r_tag2 <= r_tag1;
          if (r_tag1 != '0) begin
            r_data2 <= w_s1_data;
          end
        end
      end

      assign rd_valid = r_tag2;
      assign rd_data  = r_data2;
    end else begin : g_no_out_reg
      assign rd_valid = r_tag1;
      assign rd_data  = w_s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram_arb_sdp.sv
// Scoreboard bench for ram_arb_sdp: default build (2 channels, OUT_REG=1) plus a
// 3-channel, 16-bit, OUT_REG=0 instance, both against a behavioural memory/arbiter model.
module tb_ram_arb_sdp;

  typedef struct {
    int          ch;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic reset;

  logic        a_wr_en;
  logic [14:0] a_wr_addr;
  logic [7:0]  a_wr_data;
  logic [1:0]  a_rd_req;
  logic [29:0] a_rd_addr;
  logic [1:0]  a_rd_gnt;
  logic [1:0]  a_rd_valid;
  logic [7:0]  a_rd_data;

  logic        b_wr_en;
  logic [14:0] b_wr_addr;
  logic [15:0] b_wr_data;
  logic [2:0]  b_rd_req;
  logic [44:0] b_rd_addr;
  logic [2:0]  b_rd_gnt;
  logic [2:0]  b_rd_valid;
  logic [15:0] b_rd_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e;
  exp_t b_e;
  logic [7:0]  a_mem [int];
  logic [15:0] b_mem [int];
  int a_rr = 0;
  int b_rr = 0;

  ram_arb_sdp dut_a (
    .MEMORY_CLK(clk), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_req(a_rd_req), .rd_addr(a_rd_addr),
    .rd_gnt(a_rd_gnt), .rd_valid(a_rd_valid), .rd_data(a_rd_data)
  );

  ram_arb_sdp #(.DATA_WIDTH(16), .ADDR_WIDTH(15), .NUM_RD(3), .OUT_REG(0)) dut_b (
    .MEMORY_CLK(clk), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr),
    .rd_gnt(b_rd_gnt), .rd_valid(b_rd_valid), .rd_data(b_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first requester at or after the priority pointer, with wrap.
  function automatic int pick(input int rr, input int n, input logic [7:0] req);
    for (int k = 0; k < n; k++) begin
      if (req[(rr + k) % n]) return (rr + k) % n;
    end
    return -1;
  endfunction

  task automatic a_cycle(input bit we, input int waddr, input int wdata, input logic [1:0] req,
                         input int ad0, input int ad1, output int g);
    int addr;
    logic [7:0] d;
    @(negedge clk);
    a_wr_en   = we;
    a_wr_addr = waddr[14:0];
    a_wr_data = wdata[7:0];
    a_rd_req  = req;
    a_rd_addr = {ad1[14:0], ad0[14:0]};
    #1;
    g = reset ? -1 : pick(a_rr, 2, {6'b0, req});
    check("a_gnt", 64'(a_rd_gnt), (g < 0) ? 64'(0) : (64'(1) << g));
    if (g >= 0) begin
      addr = (g == 1) ? ad1 : ad0;
      d = a_mem[addr];
`ifdef RAM_WR_BYPASS_EN
      if (we && waddr == addr) d = wdata[7:0];
`endif
      a_q.push_back('{g, 64'(d), cyc + 2});
      a_rr = (g + 1) % 2;
    end
    if (we) a_mem[waddr] = wdata[7:0];
  endtask

  task automatic b_cycle(input bit we, input int waddr, input int wdata, input logic [2:0] req,
                         input int ad0, input int ad1, input int ad2, output int g);
    int addr;
    logic [15:0] d;
    @(negedge clk);
    b_wr_en   = we;
    b_wr_addr = waddr[14:0];
    b_wr_data = wdata[15:0];
    b_rd_req  = req;
    b_rd_addr = {ad2[14:0], ad1[14:0], ad0[14:0]};
    #1;
    g = reset ? -1 : pick(b_rr, 3, {5'b0, req});
    check("b_gnt", 64'(b_rd_gnt), (g < 0) ? 64'(0) : (64'(1) << g));
    if (g >= 0) begin
      addr = (g == 2) ? ad2 : (g == 1) ? ad1 : ad0;
      d = b_mem[addr];
`ifdef RAM_WR_BYPASS_EN
      if (we && waddr == addr) d = wdata[15:0];
`endif
      b_q.push_back('{g, 64'(d), cyc + 1});
      b_rr = (g + 1) % 3;
    end
    if (we) b_mem[waddr] = wdata[15:0];
  endtask

  always @(posedge clk) begin
    #2;
    if (a_rd_valid != '0) begin
      if (a_q.size() == 0) begin
        check("a_spurious_valid", 64'(a_rd_valid), 64'(0));
      end else begin
        a_e = a_q.pop_front();
        check("a_valid_tag", 64'(a_rd_valid), 64'(1) << a_e.ch);
        check("a_rd_data", 64'(a_rd_data), a_e.data);
        check("a_latency", 64'(cyc), 64'(a_e.due));
      end
    end else if (a_q.size() != 0 && a_q[0].due <= cyc) begin
      check("a_missing_valid", 64'(a_rd_valid), 64'(1) << a_q[0].ch);
      a_e = a_q.pop_front();
    end
  end

  always @(posedge clk) begin
    #2;
    if (b_rd_valid != '0) begin
      if (b_q.size() == 0) begin
        check("b_spurious_valid", 64'(b_rd_valid), 64'(0));
      end else begin
        b_e = b_q.pop_front();
        check("b_valid_tag", 64'(b_rd_valid), 64'(1) << b_e.ch);
        check("b_rd_data", 64'(b_rd_data), b_e.data);
        check("b_latency", 64'(cyc), 64'(b_e.due));
      end
    end else if (b_q.size() != 0 && b_q[0].due <= cyc) begin
      check("b_missing_valid", 64'(b_rd_valid), 64'(1) << b_q[0].ch);
      b_e = b_q.pop_front();
    end
  end

  initial begin
    int g;
    int pool[12];
    int bpool[4];
    logic [1:0] pend;
    logic [2:0] bpend;
    int paddr[3];

    reset = 1'b1;
    a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_rd_req = '0; a_rd_addr = '0;
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_rd_req = '0; b_rd_addr = '0;
    repeat (3) @(negedge clk);
    check("a_rst_valid", 64'(a_rd_valid), 64'(0));
    check("a_rst_data", 64'(a_rd_data), 64'(0));
    check("b_rst_valid", 64'(b_rd_valid), 64'(0));
    check("b_rst_data", 64'(b_rd_data), 64'(0));
    a_rd_req = 2'b11;
    #1;
    check("a_gnt_during_reset", 64'(a_rd_gnt), 64'(0));
    a_rd_req = '0;
    reset = 1'b0;

    // Preload: random pool words first, then the directed values so they win on any overlap.
    pool = '{0, 1, 2, 16, 256, 32767, 0, 0, 0, 0, 0, 0};
    for (int i = 6; i < 12; i++) pool[i] = $urandom_range(3, 32766);
    for (int i = 6; i < 12; i++) a_cycle(1, pool[i], $urandom_range(0, 255), 2'b00, 0, 0, g);
    a_cycle(1, 0,     'h01, 2'b00, 0, 0, g);
    a_cycle(1, 1,     'h11, 2'b00, 0, 0, g);
    a_cycle(1, 2,     'h22, 2'b00, 0, 0, g);
    a_cycle(1, 16,    'hA5, 2'b00, 0, 0, g);
    a_cycle(1, 256,   'h33, 2'b00, 0, 0, g);
    a_cycle(1, 32767, 'hFF, 2'b00, 0, 0, g);

    // Basic read of 0x0010, then continuous two-channel round-robin.
    a_cycle(0, 0, 0, 2'b01, 16, 0, g);
    a_cycle(0, 0, 0, 2'b00, 0, 0, g);
    for (int i = 0; i < 8; i++) a_cycle(0, 0, 0, 2'b11, 1, 2, g);
    a_cycle(0, 0, 0, 2'b00, 0, 0, g);

    // Same-cycle write/read collision at 0x0100, then both address extremes.
    a_cycle(1, 256, 'h5A, 2'b10, 0, 256, g);
    a_cycle(0, 0, 0, 2'b00, 0, 0, g);
    a_cycle(0, 0, 0, 2'b10, 0, 256, g);
    a_cycle(0, 0, 0, 2'b11, 32767, 0, g);
    a_cycle(0, 0, 0, 2'b11, 32767, 0, g);
    a_cycle(0, 0, 0, 2'b00, 0, 0, g);

    // Reset one cycle after a grant: the in-flight read must vanish and the pointer return to 0.
    a_cycle(0, 0, 0, 2'b01, 16, 0, g);
    @(negedge clk);
    reset = 1'b1;
    a_q.delete(); b_q.delete();
    a_rr = 0; b_rr = 0;
    a_rd_req = 2'b11;
    #1;
    check("a_gnt_in_reset", 64'(a_rd_gnt), 64'(0));
    @(negedge clk);
    check("a_midrst_valid", 64'(a_rd_valid), 64'(0));
    check("a_midrst_data", 64'(a_rd_data), 64'(0));
    a_rd_req = '0;
    reset = 1'b0;
    a_cycle(0, 0, 0, 2'b11, 1, 2, g);
    a_cycle(0, 0, 0, 2'b11, 1, 2, g);

    // Randomised traffic honouring the level-held request handshake.
    pend = '0;
    paddr = '{0, 0, 0};
    for (int t = 0; t < 400; t++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (!pend[ch]) begin
          if ($urandom_range(0, 9) < 6) begin
            pend[ch] = 1'b1;
            paddr[ch] = pool[$urandom_range(0, 11)];
          end
        end else if ($urandom_range(0, 9) == 0) begin
          pend[ch] = 1'b0;
        end
      end
      a_cycle(1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)], $urandom_range(0, 255),
              pend, paddr[0], paddr[1], g);
      if (g >= 0) pend[g] = 1'b0;
    end
    a_cycle(0, 0, 0, 2'b00, 0, 0, g);

    // Second configuration: 3 channels, 16-bit data, latency 1.
    bpool = '{0, 1, 2, 32767};
    b_cycle(1, 0,     'hBEEF, 3'b000, 0, 0, 0, g);
    b_cycle(1, 1,     'h1234, 3'b000, 0, 0, 0, g);
    b_cycle(1, 2,     'hCAFE, 3'b000, 0, 0, 0, g);
    b_cycle(1, 32767, 'hFFFF, 3'b000, 0, 0, 0, g);
    for (int i = 0; i < 7; i++) b_cycle(0, 0, 0, 3'b111, 0, 1, 2, g);
    b_cycle(0, 0, 0, 3'b000, 0, 0, 0, g);
    b_cycle(1, 2, 'h0F0F, 3'b100, 0, 0, 2, g);
    bpend = '0;
    for (int t = 0; t < 150; t++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (!bpend[ch]) begin
          if ($urandom_range(0, 9) < 5) begin
            bpend[ch] = 1'b1;
            paddr[ch] = bpool[$urandom_range(0, 3)];
          end
        end else if ($urandom_range(0, 9) == 0) begin
          bpend[ch] = 1'b0;
        end
      end
      b_cycle(1'($urandom_range(0, 1)), bpool[$urandom_range(0, 3)], $urandom_range(0, 65535),
              bpend, paddr[0], paddr[1], paddr[2], g);
      if (g >= 0) bpend[g] = 1'b0;
    end
    b_cycle(0, 0, 0, 3'b000, 0, 0, 0, g);

    repeat (5) @(negedge clk);
    check("a_queue_drained", 64'(a_q.size()), 64'(0));
    check("b_queue_drained", 64'(b_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
